// File: rtl/serial_receiver.sv
// serial_receiver: receive end of the framed serial link.
// Deserialises start(0) + WIDTH data bits (MSB first) + [parity] + stop(1)
// on Din, sampling only on BitEn strobes, and presents the word on a
// valid/ack handshake with framing-error and sticky overrun flags.
// Optional feature macro: SERIAL_RX_PARITY_EN (even parity bit + ParityErr).
module serial_receiver #(
    parameter int WIDTH = 32,
    parameter int CNT_W = $clog2(WIDTH)
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             BitEn,
    input  logic             Din,
    input  logic             RxAck,
    output logic [WIDTH-1:0] DataOut,
    output logic             RxValid,
    output logic             RxDone,
    output logic             RxBusy,
    output logic             FrameErr,
`ifdef SERIAL_RX_PARITY_EN
    output logic             ParityErr,
`endif
    output logic             Overrun
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_DATA   = 2'd1,
        S_PARITY = 2'd2,
        S_STOP   = 2'd3
    } state_e;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] shift_q, shift_d;
    logic [WIDTH-1:0] data_q, data_d;
    logic             valid_q, valid_d;
    logic             done_q, done_d;
    logic             ferr_q, ferr_d;
    logic             overrun_q, overrun_d;
    logic             parity_ok;
`ifdef SERIAL_RX_PARITY_EN
    logic             par_q, par_d;
    logic             perr_q, perr_d;
`endif

    // Even parity over data plus parity bit; always good when parity is absent.
    always_comb begin
`ifdef SERIAL_RX_PARITY_EN
        parity_ok = ~(^{shift_q, par_q});
`else
        parity_ok = 1'b1;
`endif
    end

    // Next-state, datapath and handshake logic; FSM advances only on BitEn.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        shift_d   = shift_q;
        data_d    = data_q;
        valid_d   = valid_q;
        done_d    = 1'b0;
        ferr_d    = 1'b0;
        overrun_d = overrun_q;
`ifdef SERIAL_RX_PARITY_EN
        par_d     = par_q;
        perr_d    = 1'b0;
`endif

        // An accepted ack clears valid and overrun; a completion below may
        // set valid again in the same cycle.
        if (RxAck && valid_q) begin
            valid_d   = 1'b0;
            overrun_d = 1'b0;
        end

        if (BitEn) begin
            unique case (state_q)
                S_IDLE: begin
                    if (!Din) begin
                        state_d = S_DATA;
                        cnt_d   = CNT_W'(WIDTH - 1);
                    end
                end
                S_DATA: begin
                    shift_d = {shift_q[WIDTH-2:0], Din};
                    if (cnt_q == '0) begin
`ifdef SERIAL_RX_PARITY_EN
                        state_d = S_PARITY;
`else
                        state_d = S_STOP;
`endif
                    end else begin
                        cnt_d = cnt_q - CNT_W'(1);
                    end
                end
                S_PARITY: begin
`ifdef SERIAL_RX_PARITY_EN
                    par_d = Din;
`endif
                    state_d = S_STOP;
                end
                S_STOP: begin
                    state_d = S_IDLE;
                    if (!Din) begin
                        ferr_d = 1'b1;
                    end
`ifdef SERIAL_RX_PARITY_EN
                    if (!parity_ok) begin
                        perr_d = 1'b1;
                    end
`endif
                    if (Din && parity_ok) begin
                        data_d  = shift_q;
                        valid_d = 1'b1;
                        done_d  = 1'b1;
                        if (valid_q && !RxAck) begin
                            overrun_d = 1'b1;
                        end
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    // State and output registers with synchronous active-high reset.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            shift_q   <= '0;
            data_q    <= '0;
            valid_q   <= 1'b0;
            done_q    <= 1'b0;
            ferr_q    <= 1'b0;
            overrun_q <= 1'b0;
`ifdef SERIAL_RX_PARITY_EN
            par_q     <= 1'b0;
            perr_q    <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            shift_q   <= shift_d;
            data_q    <= data_d;
            valid_q   <= valid_d;
            done_q    <= done_d;
            ferr_q    <= ferr_d;
            overrun_q <= overrun_d;
`ifdef SERIAL_RX_PARITY_EN
            par_q     <= par_d;
            perr_q    <= perr_d;
`endif
        end
    end

    assign DataOut   = data_q;
    assign RxValid   = valid_q;
    assign RxDone    = done_q;
    assign RxBusy    = (state_q != S_IDLE);
    assign FrameErr  = ferr_q;
    assign Overrun   = overrun_q;
`ifdef SERIAL_RX_PARITY_EN
    assign ParityErr = perr_q;
`endif

endmodule

// File: tb/tb_serial_receiver.sv
// Testbench for serial_receiver: directed scenarios plus randomized frames,
// checked against a frame-level reference model of the handshake state.
module tb_serial_receiver;

    localparam int WIDTH = 32;

    logic             Clk = 1'b0;
    logic             Reset = 1'b0;
    logic             BitEn = 1'b0;
    logic             Din = 1'b1;
    logic             RxAck = 1'b0;
    logic [WIDTH-1:0] DataOut;
    logic             RxValid, RxDone, RxBusy, FrameErr, Overrun;
`ifdef SERIAL_RX_PARITY_EN
    logic             ParityErr;
    logic             par_bad_g = 1'b0;
    int               perr_seen = 0;
`endif

    int checks = 0;
    int errors = 0;

    // Reference model: state of the consumer-visible word.
    logic [WIDTH-1:0] exp_data = '0;
    logic             exp_valid = 1'b0;
    logic             exp_ov = 1'b0;

    int done_seen = 0;
    int ferr_seen = 0;

    serial_receiver #(.WIDTH(WIDTH)) dut (
        .Clk      (Clk),
        .Reset    (Reset),
        .BitEn    (BitEn),
        .Din      (Din),
        .RxAck    (RxAck),
        .DataOut  (DataOut),
        .RxValid  (RxValid),
        .RxDone   (RxDone),
        .RxBusy   (RxBusy),
        .FrameErr (FrameErr),
`ifdef SERIAL_RX_PARITY_EN
        .ParityErr(ParityErr),
`endif
        .Overrun  (Overrun)
    );

    always #5 Clk = ~Clk;

    // Pulse counters sampled mid-cycle.
    always @(negedge Clk) begin
        if (RxDone) done_seen++;
        if (FrameErr) ferr_seen++;
`ifdef SERIAL_RX_PARITY_EN
        if (ParityErr) perr_seen++;
`endif
    end

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic send_bit(input logic b, input int gap, input logic ack);
        for (int i = 0; i < gap; i++) tick();
        Din   = b;
        BitEn = 1'b1;
        RxAck = ack;
        tick();
        BitEn = 1'b0;
        RxAck = 1'b0;
        Din   = 1'b1;
    endtask

    task automatic check_state(input string name);
        checks++;
        if (DataOut !== exp_data) begin
            errors++;
            $display("FAIL %s DataOut: got %h expected %h", name, DataOut, exp_data);
        end
        checks++;
        if (RxValid !== exp_valid) begin
            errors++;
            $display("FAIL %s RxValid: got %b expected %b", name, RxValid, exp_valid);
        end
        checks++;
        if (Overrun !== exp_ov) begin
            errors++;
            $display("FAIL %s Overrun: got %b expected %b", name, Overrun, exp_ov);
        end
    endtask

    task automatic send_frame(input logic [WIDTH-1:0] w, input logic stop_bit,
                              input int gmin, input int gmax, input logic ack,
                              input string name);
        logic bits[$];
        logic good;
        int   gap;
        bits.push_back(1'b0);
        for (int i = WIDTH - 1; i >= 0; i--) bits.push_back(w[i]);
`ifdef SERIAL_RX_PARITY_EN
        bits.push_back((^w) ^ par_bad_g);
        good = stop_bit && !par_bad_g;
        perr_seen = 0;
`else
        good = stop_bit;
`endif
        bits.push_back(stop_bit);
        done_seen = 0;
        ferr_seen = 0;

        for (int k = 0; k < bits.size(); k++) begin
            gap = (gmin == gmax) ? gmin : int'($urandom_range(gmax, gmin));
            send_bit(bits[k], gap, (k == bits.size() - 1) ? ack : 1'b0);
            if (k == 0) begin
                checks++;
                if (RxBusy !== 1'b1) begin
                    errors++;
                    $display("FAIL %s RxBusy after start: got %b expected 1", name, RxBusy);
                end
            end
        end

        // Frame-level model update.
        if (ack && exp_valid) begin
            exp_valid = 1'b0;
            exp_ov    = 1'b0;
        end
        if (good) begin
            if (exp_valid) exp_ov = 1'b1;
            exp_data  = w;
            exp_valid = 1'b1;
        end

        checks++;
        if (RxBusy !== 1'b0) begin
            errors++;
            $display("FAIL %s RxBusy after stop: got %b expected 0", name, RxBusy);
        end
        checks++;
        if (RxDone !== good) begin
            errors++;
            $display("FAIL %s RxDone at completion: got %b expected %b", name, RxDone, good);
        end
        check_state(name);
        tick();
        checks++;
        if (done_seen != int'(good)) begin
            errors++;
            $display("FAIL %s RxDone pulse count: got %0d expected %0d", name, done_seen, int'(good));
        end
        checks++;
        if (ferr_seen != int'(!stop_bit)) begin
            errors++;
            $display("FAIL %s FrameErr pulse count: got %0d expected %0d", name, ferr_seen, int'(!stop_bit));
        end
`ifdef SERIAL_RX_PARITY_EN
        checks++;
        if (perr_seen != int'(par_bad_g)) begin
            errors++;
            $display("FAIL %s ParityErr pulse count: got %0d expected %0d", name, perr_seen, int'(par_bad_g));
        end
`endif
    endtask

    task automatic do_ack(input string name);
        RxAck = 1'b1;
        tick();
        RxAck = 1'b0;
        if (exp_valid) begin
            exp_valid = 1'b0;
            exp_ov    = 1'b0;
        end
        check_state(name);
    endtask

    task automatic test_reset();
        Reset = 1'b1;
        tick();
        tick();
        Reset = 1'b0;
        exp_data = '0; exp_valid = 1'b0; exp_ov = 1'b0;
        check_state("reset");
        checks++;
        if ({RxDone, RxBusy, FrameErr} !== 3'b000) begin
            errors++;
            $display("FAIL reset pulses/busy: got %b expected 000", {RxDone, RxBusy, FrameErr});
        end
    endtask

    task automatic test_basic();
        send_frame(32'h12345678, 1'b1, 1, 1, 1'b0, "basic");
    endtask

    task automatic test_frame_error();
        send_frame(32'hA5A5A5A5, 1'b0, 0, 2, 1'b0, "frame_err");
        send_frame(32'h0000FFFF, 1'b1, 0, 0, 1'b0, "after_ferr");
    endtask

    task automatic test_back_to_back();
        do_ack("b2b_pre_ack");
        send_frame(32'h11111111, 1'b1, 0, 0, 1'b0, "b2b_first");
        send_frame(32'h22222222, 1'b1, 0, 0, 1'b0, "b2b_second");
        do_ack("b2b_ack");
        do_ack("ack_idle");
    endtask

    task automatic test_ack_on_completion();
        send_frame(32'h00000000, 1'b1, 0, 1, 1'b0, "ackc_pre");
        send_frame(32'hDEADBEEF, 1'b1, 0, 1, 1'b1, "ack_on_done");
    endtask

    task automatic test_reset_midframe();
        logic [WIDTH-1:0] w;
        w = 32'hCAFEF00D;
        send_bit(1'b0, 1, 1'b0);
        for (int i = 0; i < 10; i++) send_bit(w[WIDTH-1-i], 0, 1'b0);
        Reset = 1'b1;
        tick();
        Reset = 1'b0;
        exp_data = '0; exp_valid = 1'b0; exp_ov = 1'b0;
        check_state("reset_mid");
        checks++;
        if (RxBusy !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid RxBusy: got %b expected 0", RxBusy);
        end
        send_frame(32'h87654321, 1'b1, 0, 1, 1'b0, "after_reset_mid");
    endtask

`ifdef SERIAL_RX_PARITY_EN
    task automatic test_parity();
        do_ack("par_pre_ack");
        par_bad_g = 1'b0;
        send_frame(32'h00000001, 1'b1, 0, 1, 1'b0, "parity_good");
        par_bad_g = 1'b1;
        send_frame(32'h00000001, 1'b1, 0, 1, 1'b0, "parity_bad");
        send_frame(32'h0F0F0F0E, 1'b0, 0, 1, 1'b0, "parity_and_stop_bad");
        par_bad_g = 1'b0;
    endtask
`endif

    task automatic test_random();
        logic [WIDTH-1:0] w;
        logic             stop_bit;
        for (int n = 0; n < 16; n++) begin
            w        = $urandom();
            stop_bit = ($urandom_range(3, 0) != 0);
            send_frame(w, stop_bit, 0, 3, 1'($urandom_range(1, 0)), "random");
            if ($urandom_range(2, 0) == 0) do_ack("random_ack");
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_frame_error();
        test_back_to_back();
        test_ack_on_completion();
        test_reset_midframe();
`ifdef SERIAL_RX_PARITY_EN
        test_parity();
`endif
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
